// File: rtl/chipper_inject_queue.sv
// rtl/chipper_inject_queue.sv - local injection FIFO with starvation tracking for the chipper router
module chipper_inject_queue #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int STARVE_TH = 16,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [8:0]    core_flit,
  input  logic          core_valid,
  output logic          core_ready,
  output logic [9:0]    inj_flit,
  input  logic          inj_ack,
  output logic          starve,
  output logic [AW:0]   occupancy,
  output logic [15:0]   inj_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_STARVED = 2'd2
  } state_t;

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic [CW:0] L_TH   = (CW+1)'(STARVE_TH);

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_occ;
  logic [15:0]   r_inj_count;
  logic [CW-1:0] r_cnt;
  logic          r_starve;
  state_t        r_state;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_cnt_hit;
  logic          w_push;
  logic          w_pop;
  logic          w_remain;
  logic          w_head_valid;

  // Handshake decode; no bypass, so a full queue refuses even when a pop is under way
  always_comb begin
    w_head_valid = (r_occ != '0) & ~rst;
    core_ready   = (r_occ != L_FULL) & ~rst;
    inj_flit     = w_head_valid ? {1'b1, r_mem[r_rd_ptr]} : 10'b0;
    w_push       = core_valid & core_ready;
    w_pop        = inj_flit[9] & inj_ack;
    // a push alongside the pop of the last entry still leaves something to present
    w_remain     = (r_occ > (AW+1)'(1)) | w_push;
  end

  // Flit storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= core_flit;
  end

  // Pointers, occupancy and injection counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_inj_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_inj_count <= r_inj_count + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Starvation FSM state, refusal counter and registered starve flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_starve <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_starve <= (w_state_nxt == S_STARVED);
    end
  end

  // Next-state logic; the threshold compare looks one refusal ahead so starve lands on time
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
    w_cnt_hit   = ((CW+1)'(r_cnt) + (CW+1)'(1)) == L_TH;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_push) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_pop) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_remain ? S_WAIT : S_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_hit) w_state_nxt = S_STARVED;
        end
      end
      S_STARVED: begin
        if (w_pop) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_remain ? S_WAIT : S_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output drive
  always_comb begin
    starve    = r_starve;
    occupancy = r_occ;
    inj_count = r_inj_count;
  end

endmodule

// File: tb/tb_chipper_inject_queue.sv
// tb/tb_chipper_inject_queue.sv - directed self-checking bench for chipper_inject_queue
module tb_chipper_inject_queue;

  logic        clk;
  logic        rst;
  logic [8:0]  core_flit;
  logic        core_valid;
  logic        core_ready;
  logic [9:0]  inj_flit;
  logic        inj_ack;
  logic        starve;
  logic [3:0]  occupancy;
  logic [15:0] inj_count;

  int checks;
  int errors;

  chipper_inject_queue #(.DEPTH(8), .AW(3), .STARVE_TH(16), .CW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_flit  (core_flit),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .inj_flit   (inj_flit),
    .inj_ack    (inj_ack),
    .starve     (starve),
    .occupancy  (occupancy),
    .inj_count  (inj_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    core_flit  = 9'h000;
    core_valid = 1'b0;
    inj_ack    = 1'b0;
    tick();
    tick();
    check("rst_inj_flit",  32'(inj_flit),   32'h000);
    check("rst_ready",     32'(core_ready), 32'h0);
    check("rst_occ",       32'(occupancy),  32'h0);
    check("rst_starve",    32'(starve),     32'h0);
    check("rst_count",     32'(inj_count),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready",     32'(core_ready), 32'h1);

    // single flit push then ack
    core_flit  = 9'h0A5;
    core_valid = 1'b1;
    tick();
    core_valid = 1'b0;
    check("t1_flit",       32'(inj_flit),   32'h2A5);
    check("t1_occ",        32'(occupancy),  32'h1);
    check("t1_ready",      32'(core_ready), 32'h1);
    inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;
    check("t1_flit_empty", 32'(inj_flit),   32'h000);
    check("t1_count",      32'(inj_count),  32'h1);
    check("t1_occ_empty",  32'(occupancy),  32'h0);

    // fill to full, then drain in order; first drain cycle offers a push that must be refused
    for (int i = 1; i <= 8; i++) begin
      core_flit  = 9'(i);
      core_valid = 1'b1;
      tick();
    end
    core_valid = 1'b0;
    check("t2_full_ready", 32'(core_ready), 32'h0);
    check("t2_full_occ",   32'(occupancy),  32'h8);
    for (int i = 0; i < 8; i++) begin
      check("t2_order", 32'(inj_flit), 32'h200 | 32'(i + 1));
      if (i == 0) begin
        core_flit  = 9'h1FF;
        core_valid = 1'b1;
        check("t2_nobypass", 32'(core_ready), 32'h0);
      end
      inj_ack = 1'b1;
      tick();
      core_valid = 1'b0;
      if (i == 0) check("t2_occ_after_refuse", 32'(occupancy), 32'h7);
    end
    inj_ack = 1'b0;
    check("t2_drained",    32'(inj_flit),   32'h000);
    check("t2_count",      32'(inj_count),  32'd9);

    // starvation: flit appears after the push edge, starve 16 edges later
    core_flit  = 9'h055;
    core_valid = 1'b1;
    tick();
    core_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("t3_not_yet",    32'(starve),     32'h0);
    tick();
    check("t3_starve",     32'(starve),     32'h1);
    tick();
    tick();
    check("t3_hold",       32'(starve),     32'h1);
    inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;
    check("t3_clear",      32'(starve),     32'h0);
    check("t3_occ",        32'(occupancy),  32'h0);
    check("t3_count",      32'(inj_count),  32'd10);
    tick();
    check("t3_idle",       32'(starve),     32'h0);

    // steady state: occupancy 3 with simultaneous push/pop
    for (int i = 0; i < 3; i++) begin
      core_flit  = 9'(32'h101 + i);
      core_valid = 1'b1;
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      core_flit  = 9'(32'h104 + i);
      core_valid = 1'b1;
      inj_ack    = 1'b1;
      check("t4_order", 32'(inj_flit), 32'h200 | (32'h101 + 32'(i)));
      tick();
    end
    core_valid = 1'b0;
    inj_ack    = 1'b0;
    check("t4_occ",        32'(occupancy),  32'h3);
    check("t4_count",      32'(inj_count),  32'd30);
    check("t4_head",       32'(inj_flit),   32'h315);

    // build occupancy 5 and starve, then reset asynchronously mid-cycle
    core_flit  = 9'h0F0;
    core_valid = 1'b1;
    tick();
    core_flit  = 9'h0F1;
    tick();
    core_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("t5_pre_starve", 32'(starve),     32'h1);
    check("t5_pre_occ",    32'(occupancy),  32'h5);
    #2;
    rst = 1'b1;
    #1;
    check("t5_flit",       32'(inj_flit),   32'h000);
    check("t5_ready",      32'(core_ready), 32'h0);
    check("t5_starve",     32'(starve),     32'h0);
    check("t5_occ",        32'(occupancy),  32'h0);
    check("t5_count",      32'(inj_count),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    core_flit  = 9'h1C3;
    core_valid = 1'b1;
    tick();
    core_valid = 1'b0;
    check("t5_new_flit",   32'(inj_flit),   32'h3C3);
    check("t5_new_occ",    32'(occupancy),  32'h1);

    // ack while empty is ignored
    inj_ack = 1'b1;
    tick();
    check("t6_pop",        32'(inj_count),  32'h1);
    tick();
    tick();
    tick();
    inj_ack = 1'b0;
    check("t6_occ",        32'(occupancy),  32'h0);
    check("t6_count",      32'(inj_count),  32'h1);
    check("t6_flit",       32'(inj_flit),   32'h000);
    core_flit  = 9'h033;
    core_valid = 1'b1;
    tick();
    core_valid = 1'b0;
    check("t6_ptr_flit",   32'(inj_flit),   32'h233);
    check("t6_ptr_occ",    32'(occupancy),  32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
